// File: rtl/i2f_share_arbiter.sv
// rtl/i2f_share_arbiter.sv - round-robin sharing of one int->recFN32 converter among NREQ requesters
//
// Two-stage pipeline: stage A holds the granted operand and drives the external
// converter; stage B captures the converter result with the requester tag.
//
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   req_valid/req_ready       per-requester handshake (ready is one-hot or zero)
//   req_data/req_signed/req_rm  per-requester operand, signedness, rounding mode
//   cvt_in/cvt_signed/cvt_rm  to converter, driven from stage A
//   cvt_out/cvt_exc           from converter, captured into stage B
//   resp_valid/resp_ready     result handshake
//   resp_data/resp_exc/resp_tag  recoded result, flags, originating requester
//   flags_clr/acc_flags       sticky flag accumulator (I2F_ARB_FLAG_ACCUM_EN only;
//                             otherwise acc_flags is 0 and flags_clr is ignored)
//
// Optional feature macro: I2F_ARB_FLAG_ACCUM_EN

module i2f_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_data,
  input  logic [NREQ-1:0]   req_signed,
  input  logic [NREQ*3-1:0] req_rm,
  output logic [31:0]       cvt_in,
  output logic              cvt_signed,
  output logic [2:0]        cvt_rm,
  input  logic [32:0]       cvt_out,
  input  logic [4:0]        cvt_exc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [32:0]       resp_data,
  output logic [4:0]        resp_exc,
  output logic [2:0]        resp_tag,
  input  logic              flags_clr,
  output logic [4:0]        acc_flags
);

  logic [2:0]      rr_ptr;
  logic            a_valid;
  logic [31:0]     a_data;
  logic            a_signed;
  logic [2:0]      a_rm;
  logic [2:0]      a_tag;
  logic            b_valid;
  logic [32:0]     b_data;
  logic [4:0]      b_exc;
  logic [2:0]      b_tag;

  logic            b_adv;
  logic            a_adv;
  logic            a_free;
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  logic [2:0]      gnt_idx;
  logic [31:0]     sel_data;
  logic            sel_signed;
  logic [2:0]      sel_rm;
  logic [2:0]      next_ptr;

  assign b_adv  = !b_valid || resp_ready;
  assign a_adv  = a_valid && b_adv;
  assign a_free = !a_valid || a_adv;

  // Scan from rr_ptr upward with wrap; the first asserted valid wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
        gnt_idx = 3'((int'(rr_ptr) + k) % NREQ);
        gnt_any = 1'b1;
      end
    end
    // Nothing is offered while stage A cannot take it or while held in reset.
    if (!a_free || !reset_n) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    sel_data   = req_data[32*int'(gnt_idx) +: 32];
    sel_signed = req_signed[gnt_idx];
    sel_rm     = req_rm[3*int'(gnt_idx) +: 3];
    next_ptr   = (int'(gnt_idx) == NREQ-1) ? 3'd0 : gnt_idx + 3'd1;
  end

  assign req_ready  = grant;
  assign cvt_in     = a_data;
  assign cvt_signed = a_signed;
  assign cvt_rm     = a_rm;
  assign resp_valid = b_valid && reset_n;
  assign resp_data  = b_data;
  assign resp_exc   = b_exc;
  assign resp_tag   = b_tag;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr   <= 3'd0;
      a_valid  <= 1'b0;
      a_data   <= 32'd0;
      a_signed <= 1'b0;
      a_rm     <= 3'd0;
      a_tag    <= 3'd0;
      b_valid  <= 1'b0;
      b_data   <= 33'd0;
      b_exc    <= 5'd0;
      b_tag    <= 3'd0;
    end else begin
      if (gnt_any) begin
        a_valid  <= 1'b1;
        a_data   <= sel_data;
        a_signed <= sel_signed;
        a_rm     <= sel_rm;
        a_tag    <= gnt_idx;
        rr_ptr   <= next_ptr;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end

      if (a_adv) begin
        b_valid <= 1'b1;
        b_data  <= cvt_out;
        b_exc   <= cvt_exc;
        b_tag   <= a_tag;
      end else if (b_adv) begin
        b_valid <= 1'b0;
      end
    end
  end

`ifdef I2F_ARB_FLAG_ACCUM_EN
  logic [4:0] acc_q;
  logic [4:0] fire_exc;

  assign fire_exc = (resp_valid && resp_ready) ? b_exc : 5'd0;

  // A clear coinciding with a fire keeps only the firing op's flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q <= 5'd0;
    end else if (flags_clr) begin
      acc_q <= fire_exc;
    end else begin
      acc_q <= acc_q | fire_exc;
    end
  end

  assign acc_flags = acc_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign acc_flags        = 5'd0;
`endif

endmodule

// File: tb/tb_i2f_share_arbiter.sv
// tb/tb_i2f_share_arbiter.sv - directed bench for i2f_share_arbiter with a reference int->recFN32 converter

module tb_i2f_share_arbiter;

  localparam int NREQ = 4;
`ifdef I2F_ARB_FLAG_ACCUM_EN
  localparam logic [4:0] ACC_NX = 5'h01;
`else
  localparam logic [4:0] ACC_NX = 5'h00;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_signed;
  logic [NREQ*3-1:0] req_rm;
  logic [31:0]       cvt_in;
  logic              cvt_signed;
  logic [2:0]        cvt_rm;
  logic [32:0]       cvt_out;
  logic [4:0]        cvt_exc;
  logic              resp_valid;
  logic              resp_ready;
  logic [32:0]       resp_data;
  logic [4:0]        resp_exc;
  logic [2:0]        resp_tag;
  logic              flags_clr;
  logic [4:0]        acc_flags;

  int errs   = 0;
  int checks = 0;

  always #5 clock = ~clock;

  i2f_share_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_signed (req_signed),
    .req_rm     (req_rm),
    .cvt_in     (cvt_in),
    .cvt_signed (cvt_signed),
    .cvt_rm     (cvt_rm),
    .cvt_out    (cvt_out),
    .cvt_exc    (cvt_exc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_exc   (resp_exc),
    .resp_tag   (resp_tag),
    .flags_clr  (flags_clr),
    .acc_flags  (acc_flags)
  );

  // Reference int -> recFN32 (9-bit recoded exponent = 256 + msb position).
  function automatic logic [37:0] ref_cvt(input logic [31:0] x, input logic s, input logic [2:0] rm);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    int          p;
    logic        g, st, inx, up;
    logic [23:0] fr;
    logic [8:0]  e;
    sign = s & x[31];
    mag  = sign ? (~x + 32'd1) : x;
    if (mag == 32'd0) return {sign, 32'd0, 5'd0};
    p = 0;
    for (int k = 0; k < 32; k++) if (mag[k]) p = k;
    norm = mag << (31 - p);
    g    = norm[7];
    st   = |norm[6:0];
    inx  = g | st;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sign & inx;
      3'd3:    up = !sign & inx;
      3'd4:    up = g;
      default: up = g & (st | norm[8]);
    endcase
    fr = {1'b0, norm[30:8]} + {23'd0, up};
    e  = 9'(256 + p) + {8'd0, fr[23]};
    return {sign, e, fr[22:0], 4'd0, inx};
  endfunction

  always_comb {cvt_out, cvt_exc} = ref_cvt(cvt_in, cvt_signed, cvt_rm);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    flags_clr = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic s, input logic [2:0] rm);
    req_data[32*i +: 32] = d;
    req_signed[i]        = s;
    req_rm[3*i +: 3]     = rm;
  endtask

  // Single request from requester i; checks ready pulse and 2-edge latency.
  task automatic issue(input int i, input logic [31:0] d, input logic s, input logic [2:0] rm,
                       input logic [32:0] ed, input logic [4:0] ee);
    set_req(i, d, s, rm);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    #1;
    chk("issue_ready", 64'(req_ready), 64'(4'b0001 << i));
    step();
    req_valid = '0;
    #1;
    chk("issue_ready_drop", 64'(req_ready), 64'd0);
    chk("issue_lat1_valid", 64'(resp_valid), 64'd0);
    step();
    chk("issue_valid", 64'(resp_valid), 64'd1);
    chk("issue_data", 64'(resp_data), 64'(ed));
    chk("issue_exc", 64'(resp_exc), 64'(ee));
    chk("issue_tag", 64'(resp_tag), 64'(i));
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 4'hF;
    req_data   = '0;
    req_signed = '0;
    req_rm     = '0;
    resp_ready = 1'b0;
    flags_clr  = 1'b0;

    // Reset state
    step();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag), 64'd0);
    chk("rst_cvt_in", 64'(cvt_in), 64'd0);
    chk("rst_acc", 64'(acc_flags), 64'd0);
    reset_n   = 1'b1;
    req_valid = '0;

    // 1: single op, integer 1
    resp_ready = 1'b1;
    issue(0, 32'h1, 1'b1, 3'd0, 33'h080000000, 5'h00);

    // 2: all requesters valid -> grants rotate 0,1,2,3,0,1
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * (i + 1) + i, i[0], 3'(i));
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) req_valid = '0;
      #1;
      if (c < 6) chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      else       chk("rr_ready_idle", 64'(req_ready), 64'd0);
      if (c >= 2) begin
        chk("rr_valid", 64'(resp_valid), 64'd1);
        chk("rr_tag", 64'(resp_tag), 64'((c - 2) % 4));
        chk("rr_data", 64'(resp_data),
            64'(ref_cvt(32'h100 * ((c - 2) % 4 + 1) + (c - 2) % 4, (c - 2) % 2 == 1, 3'((c - 2) % 4)) >> 5));
      end
      step();
    end

    // 3: backpressure with three requests
    do_reset();
    resp_ready = 1'b0;
    set_req(0, 32'd10, 1'b0, 3'd0);
    set_req(1, 32'd20, 1'b0, 3'd0);
    set_req(2, 32'd30, 1'b0, 3'd0);
    req_valid = 4'b0111;
    #1;
    chk("bp_ready0", 64'(req_ready), 64'b0001);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("bp_ready1", 64'(req_ready), 64'b0010);
    step();
    req_valid[1] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_stall_ready", 64'(req_ready), 64'd0);
      chk("bp_stall_valid", 64'(resp_valid), 64'd1);
      chk("bp_stall_tag", 64'(resp_tag), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      if (r == 0) chk("bp_ready2", 64'(req_ready), 64'b0100);
      chk("bp_out_valid", 64'(resp_valid), 64'd1);
      chk("bp_out_tag", 64'(resp_tag), 64'(r));
      chk("bp_out_data", 64'(resp_data), 64'(ref_cvt(32'd10 * (r + 1), 1'b0, 3'd0) >> 5));
      step();
      req_valid = '0;
    end
    #1;
    chk("bp_drained", 64'(resp_valid), 64'd0);

    // 4: inexact result and flag accumulation
    do_reset();
    resp_ready = 1'b1;
    issue(3, 32'h01000001, 1'b0, 3'd0, 33'h08C000000, 5'h01);
    step();
    chk("acc_nx", 64'(acc_flags), 64'(ACC_NX));
    issue(1, 32'd3, 1'b0, 3'd0, 33'h080C00000, 5'h00);
    step();
    chk("acc_hold", 64'(acc_flags), 64'(ACC_NX));
    issue(1, 32'd3, 1'b0, 3'd0, 33'h080C00000, 5'h00);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    chk("acc_clr_fire", 64'(acc_flags), 64'd0);

    // 5: most negative int, signed vs unsigned
    issue(2, 32'h80000000, 1'b1, 3'd0, 33'h18F800000, 5'h00);
    chk("neg_sign", 64'(resp_data[32]), 64'd1);
    step();
    issue(2, 32'h80000000, 1'b0, 3'd0, 33'h08F800000, 5'h00);
    chk("pos_sign", 64'(resp_data[32]), 64'd0);
    step();

    // 6: reset with A and B full
    do_reset();
    resp_ready = 1'b0;
    set_req(3, 32'd5, 1'b0, 3'd0);
    set_req(2, 32'd6, 1'b0, 3'd0);
    set_req(0, 32'd7, 1'b0, 3'd0);
    req_valid = 4'b1000;
    #1;
    chk("mr_ready3", 64'(req_ready), 64'b1000);
    step();
    req_valid = 4'b0100;
    #1;
    chk("mr_ready2", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    #1;
    chk("mr_full_tag", 64'(resp_tag), 64'd3);
    reset_n   = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("mr_in_rst_ready", 64'(req_ready), 64'd0);
    step();
    chk("mr_in_rst_valid", 64'(resp_valid), 64'd0);
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("mr_post_valid", 64'(resp_valid), 64'd0);
    chk("mr_post_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    #1;
    chk("mr_a_only", 64'(resp_valid), 64'd0);
    step();
    chk("mr_resp_valid", 64'(resp_valid), 64'd1);
    chk("mr_resp_tag", 64'(resp_tag), 64'd0);
    chk("mr_resp_data", 64'(resp_data), 64'(ref_cvt(32'd7, 1'b0, 3'd0) >> 5));
    step();
    chk("mr_no_ghost", 64'(resp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
